// File: rtl/notes_seq_pkg.sv
// Shared types for the multi-channel note sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package notes_seq_pkg;

    // Playback controller states.
    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    // Divider value that encodes a silent step.
    localparam int DIV_REST = 0;

endpackage

// File: rtl/notes_seq_multi_tone_gen.sv
// Square-wave tone generator: toggles tone_out every div_in cycles, silent when div_in is 0.
// Latency: first toggle div_in edges after clear_in drops; output is registered.
// Backpressure: none; free-running, clear_in forces phase back to counter 0 / output low.
module tone_gen
    import notes_seq_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             clear_in,
    input  logic [DIV_W-1:0] div_in,
    output logic             tone_out
);

    logic [DIV_W-1:0] half_cnt;
    logic             is_rest;

    assign is_rest = (div_in == DIV_W'(DIV_REST));

    // Half-period counter and toggle register. A divider rewritten below the
    // current count lets the counter run on and wrap at 2^DIV_W before the
    // next toggle, which is accepted behaviour.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            half_cnt <= '0;
            tone_out <= 1'b0;
        end else if (clear_in || is_rest) begin
            half_cnt <= '0;
            tone_out <= 1'b0;
        end else if (half_cnt == div_in - DIV_W'(1)) begin
            half_cnt <= '0;
            tone_out <= ~tone_out;
        end else begin
            half_cnt <= half_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/notes_seq_multi.sv
// Multi-channel note sequencer: plays a DEPTH-step divider table per channel, TIME cycles per step.
// Latency: outputs registered; busy/step update on the start edge, first tone toggle D edges later.
// Backpressure: none; table writes accepted every cycle in any state, start ignored while playing.
module notes_seq_multi
    import notes_seq_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 8,
    parameter int DIV_W    = 16,
    parameter int TIME     = 12_000_000
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        start_in,
    input  logic                        stop_in,
    input  logic                        loop_in,
    input  logic                        wr_en_in,
    input  logic [$clog2(CHANNELS)-1:0] wr_ch_in,
    input  logic [$clog2(DEPTH)-1:0]    wr_addr_in,
    input  logic [DIV_W-1:0]            wr_div_in,
    output logic [CHANNELS-1:0]         ch_out,
    output logic [$clog2(DEPTH)-1:0]    step_out,
    output logic                        busy_out,
    output logic                        done_out
);

    localparam int ST_W  = $clog2(DEPTH);
    localparam int DUR_W = $clog2(TIME);

    localparam logic [DUR_W-1:0] DUR_LAST  = DUR_W'(TIME - 1);
    localparam logic [ST_W-1:0]  STEP_LAST = ST_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DUR_W-1:0]  dur_cnt;
    logic [DUR_W-1:0]  dur_nxt;
    logic [ST_W-1:0]   step_q;
    logic [ST_W-1:0]   step_nxt;
    logic              done_nxt;
    logic              tone_clr;

    // Divider table, one row per channel.
    logic [DIV_W-1:0]  tbl [CHANNELS][DEPTH];

    // Controller state, step duration counter, step index and done pulse.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            dur_cnt  <= '0;
            step_q   <= '0;
            done_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            dur_cnt  <= dur_nxt;
            step_q   <= step_nxt;
            done_out <= done_nxt;
        end
    end

    // Next-state logic. Stop wins over step end and loop; every step change,
    // start and stop also clears all tone generators so each step begins low
    // and phase-aligned, and IDLE holds them cleared.
    always_comb begin
        state_nxt = state;
        dur_nxt   = dur_cnt;
        step_nxt  = step_q;
        done_nxt  = 1'b0;
        tone_clr  = 1'b0;
        case (state)
            IDLE: begin
                tone_clr = 1'b1;
                if (start_in && !stop_in) begin
                    state_nxt = PLAY;
                    dur_nxt   = '0;
                    step_nxt  = '0;
                end
            end
            PLAY: begin
                if (stop_in) begin
                    state_nxt = IDLE;
                    dur_nxt   = '0;
                    step_nxt  = '0;
                    tone_clr  = 1'b1;
                end else if (dur_cnt == DUR_LAST) begin
                    dur_nxt  = '0;
                    tone_clr = 1'b1;
                    if (step_q != STEP_LAST) begin
                        step_nxt = step_q + ST_W'(1);
                    end else if (loop_in) begin
                        step_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        step_nxt  = '0;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    dur_nxt = dur_cnt + DUR_W'(1);
                end
            end
        endcase
    end

    // Table write port; a write to the entry being played is seen by its
    // tone generator from the next cycle on, without clearing its counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int c = 0; c < CHANNELS; c++) begin
                for (int s = 0; s < DEPTH; s++) begin
                    tbl[c][s] <= '0;
                end
            end
        end else if (wr_en_in) begin
            tbl[wr_ch_in][wr_addr_in] <= wr_div_in;
        end
    end

    // One tone generator per channel, fed by that channel's current step.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        tone_gen #(
            .DIV_W (DIV_W)
        ) u_tone (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .clear_in (tone_clr),
            .div_in   (tbl[c][step_q]),
            .tone_out (ch_out[c])
        );
    end

    assign busy_out = (state == PLAY);
    assign step_out = step_q;

endmodule

// File: tb/tb_notes_seq_multi.sv
// Self-checking bench for notes_seq_multi against a behavioural playback model.
// Latency: model predicts outputs one edge after the inputs it consumes.
// Backpressure: n/a.
module tb_notes_seq_multi;

    localparam int CH  = 2;
    localparam int DEP = 4;
    localparam int DW  = 8;
    localparam int TM  = 20;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic          loop_l;
    logic          wr_en;
    logic [0:0]    wr_ch;
    logic [1:0]    wr_addr;
    logic [DW-1:0] wr_div;
    logic [CH-1:0] ch_out;
    logic [1:0]    step_out;
    logic          busy_out;
    logic          done_out;

    int total = 0;
    int bad   = 0;

    notes_seq_multi #(
        .CHANNELS (CH),
        .DEPTH    (DEP),
        .DIV_W    (DW),
        .TIME     (TM)
    ) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n),
        .start_in   (start),
        .stop_in    (stop),
        .loop_in    (loop_l),
        .wr_en_in   (wr_en),
        .wr_ch_in   (wr_ch),
        .wr_addr_in (wr_addr),
        .wr_div_in  (wr_div),
        .ch_out     (ch_out),
        .step_out   (step_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Playback is tracked as elapsed cycles since start; the step is that
    // count divided by TM. Each channel keeps cycles since its last toggle.
    int m_busy;
    int m_el;
    int m_done;
    int m_ph  [CH];
    int m_tn  [CH];
    int m_tbl [CH][DEP];

    function automatic int m_step();
        return m_busy != 0 ? (m_el / TM) % DEP : 0;
    endfunction

    task automatic m_silence();
        for (int c = 0; c < CH; c++) begin
            m_ph[c] = 0;
            m_tn[c] = 0;
        end
    endtask

    task automatic m_reset();
        m_busy = 0;
        m_el   = 0;
        m_done = 0;
        m_silence();
        for (int c = 0; c < CH; c++)
            for (int s = 0; s < DEP; s++)
                m_tbl[c][s] = 0;
    endtask

    task automatic m_edge();
        int cur;
        int d;
        m_done = 0;
        if (m_busy == 0) begin
            m_silence();
            if (start && !stop) begin
                m_busy = 1;
                m_el   = 0;
            end
        end else if (stop) begin
            m_busy = 0;
            m_el   = 0;
            m_silence();
        end else begin
            cur = m_step();
            if ((m_el + 1) % TM == 0) begin
                m_silence();
                if (cur == DEP - 1 && !loop_l) begin
                    m_busy = 0;
                    m_el   = 0;
                    m_done = 1;
                end else begin
                    m_el = (m_el + 1) % (DEP * TM);
                end
            end else begin
                m_el = m_el + 1;
                for (int c = 0; c < CH; c++) begin
                    d = m_tbl[c][cur];
                    if (d == 0) begin
                        m_ph[c] = 0;
                        m_tn[c] = 0;
                    end else if (m_ph[c] == d - 1) begin
                        m_ph[c] = 0;
                        m_tn[c] = 1 - m_tn[c];
                    end else begin
                        m_ph[c] = (m_ph[c] + 1) % (1 << DW);
                    end
                end
            end
        end
        if (wr_en) m_tbl[int'(wr_ch)][int'(wr_addr)] = int'(wr_div);
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int exp_ch;
        exp_ch = 0;
        for (int c = 0; c < CH; c++) exp_ch |= (m_tn[c] << c);
        check_eq("ch_out",   int'(ch_out),   exp_ch);
        check_eq("step_out", int'(step_out), m_step());
        check_eq("busy_out", int'(busy_out), m_busy);
        check_eq("done_out", int'(done_out), m_done);
    endtask

    // One clock: model consumes the applied inputs, outputs checked 1 after
    // the edge, then single-cycle strobes drop.
    task automatic cyc();
        @(posedge clk);
        m_edge();
        #1;
        check_all();
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wr(input int c, input int a, input int d);
        wr_en   = 1'b1;
        wr_ch   = 1'(c);
        wr_addr = 2'(a);
        wr_div  = DW'(d);
        cyc();
    endtask

    int busy_cnt;
    int done_cnt;
    int done_at;

    initial begin
        clk     = 1'b0;
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_l  = 1'b0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_addr = '0;
        wr_div  = '0;
        m_reset();
        #2;
        check_all();
        #11;
        rst_n = 1'b1;

        // Load ch0 = {2,3,0,5}, ch1 = {4,0,1,2}.
        wr(0, 0, 2); wr(0, 1, 3); wr(0, 2, 0); wr(0, 3, 5);
        wr(1, 0, 4); wr(1, 1, 0); wr(1, 2, 1); wr(1, 3, 2);
        cyc();

        // One-shot playback: busy for DEP*TM samples, a single done pulse.
        loop_l   = 1'b0;
        start    = 1'b1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int n = 0; n <= 90; n++) begin
            cyc();
            busy_cnt += int'(busy_out);
            done_cnt += int'(done_out);
        end
        check_eq("oneshot_busy_cycles", busy_cnt, DEP * TM);
        check_eq("oneshot_done_pulses", done_cnt, 1);

        // Looping, then loop cleared during step 3 of the second lap.
        loop_l  = 1'b1;
        start   = 1'b1;
        cyc();
        done_at = -1;
        for (int n = 1; n <= 400; n++) begin
            if (n == 146) loop_l = 1'b0;
            cyc();
            if (done_out) begin
                done_at = n;
                break;
            end
        end
        check_eq("loop_end_cycle", done_at, 2 * DEP * TM);
        cyc();

        // Stop in step 1, cycle 7.
        start = 1'b1;
        cyc();
        for (int n = 1; n <= 26; n++) cyc();
        stop = 1'b1;
        cyc();
        check_eq("stop_busy", int'(busy_out), 0);
        check_eq("stop_ch",   int'(ch_out),   0);
        check_eq("stop_step", int'(step_out), 0);
        check_eq("stop_done", int'(done_out), 0);
        cyc();
        check_eq("stop_no_done", int'(done_out), 0);

        // Start and stop together in IDLE: stays idle.
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        check_eq("start_stop_idle", int'(busy_out), 0);
        cyc();

        // Write ch1 step 1 = 3 while step 1 plays.
        start = 1'b1;
        cyc();
        for (int n = 1; n <= 24; n++) cyc();
        wr(1, 1, 3);
        cyc();
        cyc();
        check_eq("live_write_before", int'(ch_out[1]), 0);
        cyc();
        check_eq("live_write_toggle", int'(ch_out[1]), 1);
        for (int n = 0; n < 60; n++) cyc();

        // Start pulse during PLAY is ignored.
        start = 1'b1;
        cyc();
        for (int n = 1; n <= 9; n++) cyc();
        start = 1'b1;
        cyc();
        for (int n = 11; n <= 20; n++) cyc();
        check_eq("restart_ignored_step", int'(step_out), 1);
        for (int n = 0; n < 70; n++) cyc();

        // Randomized traffic, including occasional large dividers.
        for (int n = 0; n < 1500; n++) begin
            start = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 59) == 0) loop_l = ~loop_l;
            if ($urandom_range(0, 7) == 0) begin
                wr_en   = 1'b1;
                wr_ch   = 1'($urandom_range(0, CH - 1));
                wr_addr = 2'($urandom_range(0, DEP - 1));
                wr_div  = ($urandom_range(0, 9) < 7) ? DW'($urandom_range(0, 6))
                                                     : DW'($urandom_range(0, 255));
            end
            cyc();
        end
        stop   = 1'b1;
        loop_l = 1'b0;
        cyc();

        // Asynchronous reset in the middle of playback.
        start = 1'b1;
        cyc();
        for (int n = 0; n < 33; n++) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all();
        #3;
        rst_n = 1'b1;
        start = 1'b1;
        cyc();
        check_eq("post_reset_busy", int'(busy_out), 1);
        for (int n = 0; n < 90; n++) begin
            cyc();
            check_eq("post_reset_rest", int'(ch_out), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/notes_seq_multi.md
# notes_seq_multi

Parametrised multi-channel note sequencer, successor to the single-channel note sequencer. Each channel plays a programmable table of DEPTH tone steps, each lasting TIME clock cycles, as a square wave whose half-period is a per-step divider value (0 = rest). Playback is started and stopped by control pulses and runs once or loops. The block sits between the control logic (table loading, start/stop) and the audio output pins.

## Interface
- CHANNELS, 2: number of independent tone channels, ≥2
- DEPTH, 8: steps per channel table, power of two, ≥2
- DIV_W, 16: width of a divider (half-period in clock cycles)
- TIME, 12_000_000: clock cycles per step, ≥2
- clk_in  input  1  system clock, all logic on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- start_in  input  1  single-cycle pulse, begins playback from step 0
- stop_in  input  1  single-cycle pulse, aborts playback
- loop_in  input  1  level; 1 = wrap after last step, 0 = one-shot
- wr_en_in  input  1  table write strobe
- wr_ch_in  input  $clog2(CHANNELS)  channel to write
- wr_addr_in  input  $clog2(DEPTH)  step to write
- wr_div_in  input  DIV_W  divider value to write
- ch_out  output  CHANNELS  square-wave output per channel
- step_out  output  $clog2(DEPTH)  current step index
- busy_out  output  1  high while playing
- done_out  output  1  one-cycle pulse at natural end of one-shot playback

## Operation
- Reset: state IDLE, all table entries 0, ch_out=0, step_out=0, busy_out=0, done_out=0, all counters 0.
- FSM states: IDLE, PLAY.
- IDLE → PLAY on start_in && !stop_in; step=0, duration counter=0, tone counters=0, ch_out=0.
- PLAY: duration counter counts 0..TIME-1. At TIME-1: step<DEPTH-1 → step+1; step=DEPTH-1 → loop_in (sampled that cycle) ? step=0 : IDLE with done_out=1 for one cycle.
- PLAY → IDLE on stop_in (highest priority, overrides step end and loop). No done_out; ch_out=0, step_out=0.
- start_in while in PLAY is ignored. stop_in in IDLE is ignored.
- Tone per channel: D = table[ch][step]. D=0: ch_out[ch]=0, counter held 0. D≠0: counter increments each cycle; at counter==D-1 toggle ch_out[ch], counter=0. Output frequency f_clk/(2·D).
- On every step change (including loop wrap): all tone counters and ch_out cleared, so each step starts phase-aligned, low.
- Writes accepted in any state, one per cycle. A write to the currently playing entry takes effect on the following cycle; the tone counter is not cleared, so if new D ≤ counter the counter wraps at 2^DIV_W (documented, not an error).
- In IDLE ch_out stays 0 regardless of table contents.

## Timing
- start_in sampled at edge k: busy_out=1, step_out=0 after edge k; channel with D≠0 first toggles at edge k+D.
- Each step lasts exactly TIME cycles; step_out changes at edges k+n·TIME.
- One-shot: busy_out high for DEPTH·TIME cycles; done_out asserted on the same edge busy_out falls, for one cycle.
- stop_in at edge j: busy_out=0, ch_out=0 after edge j.
- All outputs registered; no combinational input-to-output paths.

## Structure
- Package notes_seq_pkg: state enum (IDLE, PLAY), DIV_REST = 0.
- Sub-module tone_gen: one instance per channel via generate loop; ports clk_in, rst_n_in, clear_in, div_in[DIV_W], tone_out. Holds half-period counter and toggle register.
- Top holds FSM, duration counter, step counter and the CHANNELS×DEPTH divider register array.

## Test plan
Bench parameters CHANNELS=2, DEPTH=4, DIV_W=8, TIME=20.
- Reset mid-playback (rst_n_in low at arbitrary cycle) → all outputs 0 immediately, table cleared, start_in afterwards plays only rests.
- Load ch0 = {2,3,0,5}, ch1 = {4,0,1,2}, loop_in=0, start → ch0 toggles every 2 cycles in step 0, ch1 every 4; step 2 ch0 flat 0; step_out 0→1→2→3 every 20 cycles; busy 80 cycles; done_out single pulse.
- Same table, loop_in=1 → step_out wraps 3→0 after 80 cycles, ch_out cleared at wrap; clear loop_in during step 3 → one-shot end at 160 cycles with done_out.
- stop_in in step 1, cycle 7 → next cycle busy_out=0, ch_out=0, step_out=0, no done_out; stop_in+start_in same cycle in IDLE → stays IDLE.
- Write ch1 step 1 = 3 during step 1 playback → ch1 starts toggling every 3 cycles from the following cycle.
- start_in pulse during PLAY → no effect on step_out or duration counter.
